pipeline_hazard_ctrl: RTL and testbench

// - Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
// - Detects load-use hazards, taken-branch flushes, data-memory wait and halt.
// - Drives the per-stage stall/nop/WEN controls, tracks halt drain, and counts stall/flush events.

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Provides the FSM state encoding, the canonical nop encoding, the
// active-low register write-enable levels and a source/destination match helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Pipeline register enables are active-low.
  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_HOLD  = 1'b1;

  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on clr.
// Ports: clk, clr (synchronous, dominant), inc, q[W-1:0].
// One cycle from inc to updated q.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC.
// Inputs: D/E hazard info, taken branch, halt, dmem request/ack. Outputs: PC_WEN,
// per-stage stall/nop/WEN (Mealy, same cycle), halted, sticky mem_timeout, event counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DRAIN_CYC   = 3,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             UsesRs1_D,
  input  logic             UsesRs2_D,
  input  logic [4:0]       Rdst_E,
  input  logic             RegWrEn_E,
  input  logic             IsLoad_E,
  input  logic             didBranch_E,
  input  logic             halt_D,
  input  logic             dmem_req_M,
  input  logic             dmem_ack,
  output logic             PC_WEN,
  output logic             IF_ID_stall,
  output logic             IF_ID_nop,
  output logic             ID_EX_stall,
  output logic             ID_EX_nop,
  output logic             EX_MEM_WEN,
  output logic             MEM_WB_WEN,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic            memwait, loaduse, freeze, stall_inc, flush_inc;

  assign memwait = dmem_req_M & ~dmem_ack;
  assign loaduse = IsLoad_E & ~RegWrEn_E & (Rdst_E != 5'd0) &
                   (reg_match(UsesRs1_D, Rs1_D, Rdst_E) |
                    reg_match(UsesRs2_D, Rs2_D, Rdst_E));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
      if (state_nxt == MEMWAIT && wait_nxt >= WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    drain_nxt   = drain_cnt;
    freeze      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    halted      = 1'b0;
    PC_WEN      = WEN_WRITE;
    IF_ID_stall = 1'b0;
    IF_ID_nop   = 1'b0;
    ID_EX_stall = 1'b0;
    ID_EX_nop   = 1'b0;
    EX_MEM_WEN  = WEN_WRITE;
    MEM_WB_WEN  = WEN_WRITE;

    case (state)
      HALTED: begin
        freeze = 1'b1;
        halted = 1'b1;
      end
      DRAIN: begin
        // A memory wait freezes everything and pauses the drain count.
        if (memwait) begin
          freeze = 1'b1;
        end else begin
          PC_WEN    = WEN_HOLD;
          IF_ID_nop = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt = HALTED;
          end else begin
            drain_nxt = drain_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (state == MEMWAIT && !dmem_ack) begin
          freeze    = 1'b1;
          stall_inc = 1'b1;
          if (wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          // Plain RUN, or the ack cycle that releases MEMWAIT: decode normally.
          state_nxt = RUN;
          if (memwait) begin
            freeze    = 1'b1;
            stall_inc = 1'b1;
            state_nxt = MEMWAIT;
            wait_nxt  = WW'(1);
          end else if (didBranch_E) begin
            // Wrong-path D instruction: its hazard and halt are discarded.
            IF_ID_nop = 1'b1;
            ID_EX_nop = 1'b1;
            flush_inc = 1'b1;
          end else if (loaduse) begin
            PC_WEN      = WEN_HOLD;
            IF_ID_stall = 1'b1;
            ID_EX_nop   = 1'b1;
            stall_inc   = 1'b1;
          end else if (halt_D) begin
            PC_WEN    = WEN_HOLD;
            IF_ID_nop = 1'b1;
            state_nxt = DRAIN;
            drain_nxt = '0;
          end
        end
      end
    endcase

    if (freeze) begin
      PC_WEN      = WEN_HOLD;
      IF_ID_stall = 1'b1;
      ID_EX_stall = 1'b1;
      EX_MEM_WEN  = WEN_HOLD;
      MEM_WB_WEN  = WEN_HOLD;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default instance and a small one (CNT_W=4, MEM_TIMEOUT=2)
// share one stimulus stream; a cycle-level reference model predicts controls and counters.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] Rs1_D, Rs2_D, Rdst_E;
  logic       UsesRs1_D, UsesRs2_D, RegWrEn_E, IsLoad_E;
  logic       didBranch_E, halt_D, dmem_req_M, dmem_ack;

  logic        PC_WEN, IF_ID_stall, IF_ID_nop, ID_EX_stall, ID_EX_nop;
  logic        EX_MEM_WEN, MEM_WB_WEN, halted, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_PC_WEN, s_IF_ID_stall, s_IF_ID_nop, s_ID_EX_stall, s_ID_EX_nop;
  logic        s_EX_MEM_WEN, s_MEM_WB_WEN, s_halted, s_mem_timeout;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .UsesRs1_D(UsesRs1_D), .UsesRs2_D(UsesRs2_D), .Rdst_E(Rdst_E),
    .RegWrEn_E(RegWrEn_E), .IsLoad_E(IsLoad_E), .didBranch_E(didBranch_E),
    .halt_D(halt_D), .dmem_req_M(dmem_req_M), .dmem_ack(dmem_ack),
    .PC_WEN(PC_WEN), .IF_ID_stall(IF_ID_stall), .IF_ID_nop(IF_ID_nop),
    .ID_EX_stall(ID_EX_stall), .ID_EX_nop(ID_EX_nop), .EX_MEM_WEN(EX_MEM_WEN),
    .MEM_WB_WEN(MEM_WB_WEN), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(3), .MEM_TIMEOUT(2)) dut_s (
    .CLK(CLK), .RST(RST), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .UsesRs1_D(UsesRs1_D), .UsesRs2_D(UsesRs2_D), .Rdst_E(Rdst_E),
    .RegWrEn_E(RegWrEn_E), .IsLoad_E(IsLoad_E), .didBranch_E(didBranch_E),
    .halt_D(halt_D), .dmem_req_M(dmem_req_M), .dmem_ack(dmem_ack),
    .PC_WEN(s_PC_WEN), .IF_ID_stall(s_IF_ID_stall), .IF_ID_nop(s_IF_ID_nop),
    .ID_EX_stall(s_ID_EX_stall), .ID_EX_nop(s_ID_EX_nop), .EX_MEM_WEN(s_EX_MEM_WEN),
    .MEM_WB_WEN(s_MEM_WB_WEN), .halted(s_halted), .mem_timeout(s_mem_timeout),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;
  localparam int A_NONE = 0, A_WAIT_START = 1, A_WAIT = 2, A_FLUSH = 3, A_BUBBLE = 4,
                 A_HALT = 5, A_DRAIN = 6, A_DRAIN_FRZ = 7, A_HALTED = 8;

  int     ms, m_wc, m_drain;
  longint m_stall, m_flush;
  bit     m_to_big, m_to_small;

  task automatic model_reset();
    ms = M_RUN; m_wc = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    m_to_big = 0; m_to_small = 0;
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic int decide();
    bit mw, lu;
    mw = dmem_req_M && !dmem_ack;
    lu = IsLoad_E && !RegWrEn_E && (Rdst_E != 0) &&
         ((UsesRs1_D && Rs1_D == Rdst_E) || (UsesRs2_D && Rs2_D == Rdst_E));
    if (ms == M_HALT) return A_HALTED;
    if (ms == M_DRAIN) return mw ? A_DRAIN_FRZ : A_DRAIN;
    if (ms == M_WAIT && !dmem_ack) return A_WAIT;
    if (mw) return A_WAIT_START;
    if (didBranch_E) return A_FLUSH;
    if (lu) return A_BUBBLE;
    if (halt_D) return A_HALT;
    return A_NONE;
  endfunction

  // {PC_WEN, IF_ID_stall, IF_ID_nop, ID_EX_stall, ID_EX_nop, EX_MEM_WEN, MEM_WB_WEN}
  function automatic logic [6:0] ctl_of(input int act);
    case (act)
      A_WAIT_START, A_WAIT, A_DRAIN_FRZ, A_HALTED: return 7'b1101011;
      A_FLUSH:         return 7'b0010100;
      A_BUBBLE:        return 7'b1100100;
      A_HALT, A_DRAIN: return 7'b1010000;
      default:         return 7'b0000000;
    endcase
  endfunction

  task automatic model_apply(input int act);
    case (act)
      A_WAIT_START: begin ms = M_WAIT; m_wc = 1; m_stall++; end
      A_WAIT:       begin m_wc++; m_stall++; end
      A_FLUSH:      begin ms = M_RUN; m_flush++; end
      A_BUBBLE:     begin ms = M_RUN; m_stall++; end
      A_HALT:       begin ms = M_DRAIN; m_drain = 0; end
      A_DRAIN:      begin m_drain++; if (m_drain == 3) ms = M_HALT; end
      A_NONE:       ms = M_RUN;
      default: ;
    endcase
    if (act == A_WAIT_START || act == A_WAIT) begin
      if (m_wc >= 64) m_to_big = 1;
      if (m_wc >= 2)  m_to_small = 1;
    end
  endtask

  // One clock: check registered state and Mealy controls at negedge, then advance model.
  task automatic cyc();
    int act;
    logic [6:0] exp_ctl;
    @(negedge CLK);
    chk("stall_cnt", stall_cnt, sat(m_stall, 32));
    chk("flush_cnt", flush_cnt, sat(m_flush, 32));
    chk("s_stall_cnt", s_stall_cnt, sat(m_stall, 4));
    chk("s_flush_cnt", s_flush_cnt, sat(m_flush, 4));
    chk("halted", {s_halted, halted}, {2{ms == M_HALT}});
    chk("mem_timeout", {s_mem_timeout, mem_timeout}, {m_to_small, m_to_big});
    act = decide();
    exp_ctl = ctl_of(act);
    chk("ctl", {PC_WEN, IF_ID_stall, IF_ID_nop, ID_EX_stall, ID_EX_nop, EX_MEM_WEN, MEM_WB_WEN}, exp_ctl);
    chk("s_ctl", {s_PC_WEN, s_IF_ID_stall, s_IF_ID_nop, s_ID_EX_stall, s_ID_EX_nop,
                  s_EX_MEM_WEN, s_MEM_WB_WEN}, exp_ctl);
    chk("stall_nop_excl", (IF_ID_stall & IF_ID_nop) | (ID_EX_stall & ID_EX_nop), 0);
    if (RST) model_reset();
    else     model_apply(act);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; Rs1_D = 1; Rs2_D = 2; Rdst_E = 3; UsesRs1_D = 0; UsesRs2_D = 0;
    RegWrEn_E = 1; IsLoad_E = 0; didBranch_E = 0; halt_D = 0; dmem_req_M = 0; dmem_ack = 0;
  endtask

  task automatic set_loaduse();
    idle();
    IsLoad_E = 1; RegWrEn_E = 0; Rdst_E = 5; UsesRs1_D = 1; Rs1_D = 5;
  endtask

  initial begin
    idle();
    RST = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    cyc();                       // reset held: default controls, counters 0
    idle(); cyc();

    // Load-use: exactly one bubble when the hazard is present for one cycle
    set_loaduse(); cyc();
    idle(); cyc();
    chk("lu_stall_cnt", stall_cnt, 1);

    // Load to x0 never stalls
    set_loaduse(); Rdst_E = 0; Rs1_D = 0; cyc();
    idle(); cyc();
    chk("x0_stall_cnt", stall_cnt, 1);

    // Branch together with load-use and halt: flush wins
    set_loaduse(); didBranch_E = 1; halt_D = 1; cyc();
    idle(); cyc();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_halted", halted, 0);

    // Mem wait: four frozen cycles, release on ack
    idle(); dmem_req_M = 1;
    repeat (4) cyc();
    dmem_ack = 1; cyc();
    idle(); cyc(); cyc();
    chk("mw_stall_cnt", stall_cnt, 5);
    chk("mw_timeout_small", s_mem_timeout, 1);
    chk("mw_timeout_big", mem_timeout, 0);

    // Halt: one entry cycle, three drain cycles (one frozen by mem wait), then halted
    idle(); halt_D = 1; cyc();
    idle(); didBranch_E = 1; cyc();
    idle(); dmem_req_M = 1; cyc();
    idle(); cyc(); cyc();
    repeat (3) cyc();
    chk("halt_halted", halted, 1);

    // Reset during the second drain cycle
    RST = 1; cyc();
    idle(); halt_D = 1; cyc();
    idle(); cyc();
    RST = 1; cyc();
    idle(); cyc();
    chk("rst_drain_halted", halted, 0);
    chk("rst_drain_stall", stall_cnt, 0);
    chk("rst_drain_timeout", s_mem_timeout, 0);

    // Saturation: 20 consecutive load-use stalls
    set_loaduse(); Rs2_D = 5; UsesRs2_D = 1; UsesRs1_D = 0;
    repeat (20) cyc();
    idle(); cyc();
    chk("sat_small", s_stall_cnt, 4'hF);
    chk("sat_big", stall_cnt, 20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 59) == 0);
      Rs1_D       = 5'($urandom_range(0, 3));
      Rs2_D       = 5'($urandom_range(0, 3));
      Rdst_E      = 5'($urandom_range(0, 3));
      UsesRs1_D   = 1'($urandom_range(0, 1));
      UsesRs2_D   = 1'($urandom_range(0, 1));
      RegWrEn_E   = ($urandom_range(0, 3) == 0);
      IsLoad_E    = 1'($urandom_range(0, 1));
      didBranch_E = ($urandom_range(0, 7) == 0);
      halt_D      = ($urandom_range(0, 15) == 0);
      dmem_req_M  = ($urandom_range(0, 2) == 0);
      dmem_ack    = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
